// File: rtl/ssc_pkg.sv
// Shared FSM encoding, default parameter values and sizing helper for the ADC averager.
package ssc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } adc_state_e;

    localparam int DEF_NB_DATA      = 12;
    localparam int DEF_LOG2_AVG     = 2;
    localparam int DEF_CONVST_WIDTH = 4;
    localparam int DEF_TIMEOUT_CYC  = 1024;

    // Width able to hold (max(a,b) - 1), the largest value ever loaded into the cycle counter.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/adc_cycle_counter.sv
// Loadable down-counter used for the convst pulse width and the WAIT timeout.
module adc_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/adc_sample_averager.sv
// Triggers 2^LOG2_AVG XADC conversions and returns their truncated mean.
// Optional WAIT watchdog enabled by defining ADC_TIMEOUT_EN.
module adc_sample_averager
    import ssc_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int LOG2_AVG     = DEF_LOG2_AVG,
    parameter int CONVST_WIDTH = DEF_CONVST_WIDTH,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_trigger,
    input  logic [NB_DATA-1:0] i_adc_val,
    input  logic               i_adc_eoc,
    output logic               o_adc_convst,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int ACC_W  = NB_DATA + LOG2_AVG;
    localparam int SCNT_W = LOG2_AVG + 1;
    localparam int CNT_W  = cnt_width(CONVST_WIDTH, TIMEOUT_CYC);
    localparam logic [SCNT_W-1:0] N_SAMPLES = SCNT_W'(1 << LOG2_AVG);
    localparam logic [CNT_W-1:0]  CONV_LOAD = CNT_W'(CONVST_WIDTH - 1);

    adc_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0]   cnt_load_val;
`ifdef ADC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    logic               timeout_q, timeout_d;
`endif

    adc_cycle_counter #(.W(CNT_W)) u_cycle_counter (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .i_en       (cnt_en),
        .o_tc       (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        scnt_d       = scnt_q;
        result_d     = result_q;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = CONV_LOAD;
`ifdef ADC_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_trigger) begin
                    state_d  = ST_CONV;
                    acc_d    = '0;
                    scnt_d   = '0;
                    cnt_load = 1'b1;
`ifdef ADC_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_CONV: begin
                if (cnt_tc) begin
                    state_d = ST_WAIT;
`ifdef ADC_TIMEOUT_EN
                    cnt_load     = 1'b1;
                    cnt_load_val = TMO_LOAD;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_adc_eoc) begin
                    state_d = ST_ACCUM;
                    acc_d   = acc_q + ACC_W'(i_adc_val);
                end
`ifdef ADC_TIMEOUT_EN
                // A timed-out request still completes, but leaves the old result in place.
                else if (cnt_tc) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
`endif
            end
            ST_ACCUM: begin
                scnt_d = scnt_q + SCNT_W'(1);
                if (scnt_d == N_SAMPLES) begin
                    state_d  = ST_DONE;
                    result_d = NB_DATA'(acc_q >> LOG2_AVG);
                end else begin
                    state_d  = ST_CONV;
                    cnt_load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            scnt_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            result_q <= result_d;
        end
    end

`ifdef ADC_TIMEOUT_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_adc_convst = (state_q == ST_CONV);
    assign o_done       = (state_q == ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_result     = result_q;

endmodule
